// File: rtl/delay_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// delay_sequencer_pkg
//   Shared definitions for the delay sequencer and its command FIFO.
//   Contents:
//     S_IDLE/S_LOAD/S_ARM/S_WAIT : 2-bit FSM state encodings
//     state_is_busy()            : decodes the externally visible busy flag
//   The optional abort feature of the top level is enabled by defining
//   DELAY_SEQUENCER_ABORT_EN.
// -----------------------------------------------------------------------------
package delay_sequencer_pkg;

  localparam int STATE_W = 2;

  localparam logic [1:0] S_IDLE = 2'd0;  // nothing queued, waiting for a push
  localparam logic [1:0] S_LOAD = 2'd1;  // pop head, latch data/count
  localparam logic [1:0] S_ARM  = 2'd2;  // tm_put strobe is on the bus
  localparam logic [1:0] S_WAIT = 2'd3;  // waiting for the timer to expire

  // Busy is simply "not idle"; kept here so every user decodes it the same way.
  function automatic logic state_is_busy(input logic [1:0] st);
    return (st != S_IDLE);
  endfunction

endpackage

// File: rtl/delay_sequencer_fifo.sv
// -----------------------------------------------------------------------------
// seq_fifo
//   Synchronous command FIFO for delay_sequencer. 2**A entries of WIDTH bits.
//   Pointers carry one extra wrap bit so that full and empty are told apart
//   without a separate occupancy counter.
// Ports
//   clk      in   1      clock, rising edge
//   rst      in   1      asynchronous active-high reset, empties the FIFO
//   i_flush  in   1      synchronous flush; wins over a same-cycle push/pop
//   i_push   in   1      write strobe, ignored while o_full
//   i_wdata  in   WIDTH  write data
//   i_pop    in   1      read strobe, ignored while o_empty
//   o_rdata  out  WIDTH  head entry (valid while o_empty is low)
//   o_full   out  1      all 2**A entries occupied
//   o_empty  out  1      no entries
// -----------------------------------------------------------------------------
module seq_fifo
  import delay_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int A     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int DEPTH = 2 ** A;

  logic [A:0]       r_wr_ptr;
  logic [A:0]       r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_push_ok;
  logic w_pop_ok;

  // Full/empty come straight from the pointer registers, so they reflect the
  // state before the edge: a push while full is dropped even if a pop happens
  // in the same cycle.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[A-1:0] == r_rd_ptr[A-1:0]) &&
                     (r_wr_ptr[A] != r_rd_ptr[A]);
  assign w_push_ok = i_push & ~o_full & ~i_flush;
  assign w_pop_ok  = i_pop & ~o_empty & ~i_flush;
  assign o_rdata   = r_mem[r_rd_ptr[A-1:0]];

  // Pointer update; a flush collapses both pointers back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + {{A{1'b0}}, 1'b1};
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + {{A{1'b0}}, 1'b1};
      end
    end
  end

  // Storage array; contents are only read when non-empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[A-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/delay_sequencer.sv
// -----------------------------------------------------------------------------
// delay_sequencer
//   Upstream feeder for a timeout counter. Queues (count, data) steps in a
//   small FIFO; for each step it shows data on out_data, pulses tm_put for one
//   cycle with tm_count = count, then waits for the timer to report expiry
//   (tm_full low) before starting the next step. A step of count N lasts
//   N + 3 clocks (LOAD, ARM, final WAIT cycle); consecutive steps run with no
//   IDLE gap.
// Parameters
//   W  width of the count field (matches the timeout counter)
//   D  width of the data pattern
//   A  log2 of the FIFO depth
// Ports
//   clock     in   1  system clock, rising edge
//   reset     in   1  asynchronous active-high; clears FIFO, FSM and outputs
//   in_count  in   W  step duration in clocks
//   in_data   in   D  step output pattern
//   in_put    in   1  push strobe (one entry per cycle while in_full low)
//   in_full   out  1  FIFO full; pushes are dropped
//   out_data  out  D  pattern of the current/last step, held after drain
//   tm_count  out  W  count for the timer, valid while tm_put high
//   tm_put    out  1  one-cycle load strobe to the timer
//   tm_full   in   1  timer busy; low means expired/idle
//   busy      out  1  high in every state except IDLE
//   abort     in   1  only with DELAY_SEQUENCER_ABORT_EN: flushes the FIFO and
//                     forces IDLE; out_data keeps its value
// Configuration macro: DELAY_SEQUENCER_ABORT_EN
// -----------------------------------------------------------------------------
module delay_sequencer
  import delay_sequencer_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 8,
  parameter int A = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] in_count,
  input  logic [D-1:0] in_data,
  input  logic         in_put,
  output logic         in_full,
  output logic [D-1:0] out_data,
  output logic [W-1:0] tm_count,
  output logic         tm_put,
  input  logic         tm_full,
  output logic         busy
`ifdef DELAY_SEQUENCER_ABORT_EN
  ,
  input  logic         abort
`endif
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic [D-1:0]       r_data;
  logic [W-1:0]       r_count;
  logic               r_put;
  logic               r_busy;

  logic               w_abort;
  logic               w_load;
  logic               w_fifo_empty;
  logic [W+D-1:0]     w_head;
  logic [W-1:0]       w_head_count;
  logic [D-1:0]       w_head_data;

`ifdef DELAY_SEQUENCER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Entries are packed {count, data} with count in the upper bits.
  assign w_head_count = w_head[W+D-1:D];
  assign w_head_data  = w_head[D-1:0];

  // LOAD is the only state that consumes an entry; an abort in the same cycle
  // discards it together with the rest of the queue.
  assign w_load = (r_state == S_LOAD) && !w_abort;

  seq_fifo #(
    .WIDTH (W + D),
    .A     (A)
  ) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .i_flush (w_abort),
    .i_push  (in_put),
    .i_wdata ({in_count, in_data}),
    .i_pop   (w_load),
    .o_rdata (w_head),
    .o_full  (in_full),
    .o_empty (w_fifo_empty)
  );

  // Next-state logic. tm_full is ignored outside WAIT: during ARM the timer has
  // not yet seen the strobe, and in IDLE a foreign load must not start a step.
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_fifo_empty) begin
            w_state_nxt = S_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_LOAD: w_state_nxt = S_ARM;
        S_ARM:  w_state_nxt = S_WAIT;
        S_WAIT: begin
          if (tm_full) begin
            w_state_nxt = S_WAIT;
          end else if (!w_fifo_empty) begin
            w_state_nxt = S_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State and output registers; out_data/tm_count only change on a load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_count <= '0;
      r_put   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= state_is_busy(w_state_nxt);
      r_put   <= w_load;
      if (w_load) begin
        r_data  <= w_head_data;
        r_count <= w_head_count;
      end
    end
  end

  assign out_data = r_data;
  assign tm_count = r_count;
  assign tm_put   = r_put;
  assign busy     = r_busy;

endmodule
